// File: rtl/rtl_handshake_source.sv
// Valid/ready word generator: on start, emits count words base, base+1, ... through a
// 2-entry output FIFO, with a programmable number of idle cycles between generator pushes.
//
// state | meaning
// IDLE  | waiting for start; count/base/gap are latched on accept
// RUN   | generator pushes words into the FIFO until remaining reaches 0
// DRAIN | generator finished; waiting for the FIFO to empty, then pulse done
module rtl_handshake_source #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] base,
  input  logic [GAP_W-1:0] gap,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic [WIDTH-1:0] data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] sent_q;
  logic [WIDTH-1:0] next_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [WIDTH-1:0] mem0_q;
  logic [WIDTH-1:0] mem1_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;

  logic push;
  logic pop;

  // Push looks only at the current occupancy, so a full FIFO never accepts a word
  // in the same cycle it pops one.
  assign push = (state_q == S_RUN) && (occ_q != 2'd2) && (rem_q != '0) && (gap_cnt_q == '0);
  assign pop  = (occ_q != 2'd0) && handshake_ready;

  assign handshake_valid = (occ_q != 2'd0);
  assign data            = rd_ptr_q ? mem1_q : mem0_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign sent            = sent_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      sent_q    <= '0;
      next_q    <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      mem0_q    <= '0;
      mem1_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      done_q <= 1'b0;

      if (push) begin
        if (wr_ptr_q) mem1_q <= next_q;
        else          mem0_q <= next_q;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (sent_q != cnt_q) sent_q <= sent_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase

      case (state_q)
        S_IDLE: begin
          if (start) begin
            sent_q <= '0;
            cnt_q  <= count;
            if (count != '0) begin
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
              rem_q     <= count;
              next_q    <= base;
              gap_q     <= gap;
              gap_cnt_q <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (push) begin
            next_q    <= next_q + 1'b1;
            rem_q     <= rem_q - 1'b1;
            gap_cnt_q <= gap_q;
            if (rem_q == CNT_W'(1)) state_q <= S_DRAIN;
          end else if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        S_DRAIN: begin
          // Finish on the edge that pops the last word, so done follows it by one cycle.
          if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
